// File: rtl/rob_commit_pkg.sv
// Shared types for the reorder-buffer commit slice.
// Default sizes apply only when no CPU-wide configuration header has defined them.
`ifndef ROB_SIZE
`define ROB_SIZE 4
`endif
`ifndef NUM_D_REG
`define NUM_D_REG 16
`endif
`ifndef NUM_S_REG
`define NUM_S_REG 8
`endif

package rob_commit_pkg;

  localparam int D_ADDR_W = $clog2(`NUM_D_REG);
  localparam int S_ADDR_W = $clog2(`NUM_S_REG);

  typedef struct packed {
    logic                occupied;
    logic                done;
    logic                write_d;
    logic [D_ADDR_W-1:0] prev_rw_addr;
    logic                write_s;
    logic [S_ADDR_W-1:0] prev_rs_addr;
  } rob_entry_t;

endpackage

// File: rtl/rob_ptr.sv
// Wrapping ROB pointer; relies on the buffer depth being a power of two.
module rob_ptr #(
  parameter int WIDTH = 2
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             inc,
  output logic [WIDTH-1:0] ptr
);

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      ptr <= '0;
    end else if (inc) begin
      ptr <= ptr + WIDTH'(1);
    end
  end

endmodule

// File: rtl/rob_commit.sv
// Reorder buffer: in-order allocation, out-of-order completion, in-order single retire
// with registered commit and free-list strobes.
module rob_commit
  import rob_commit_pkg::*;
#(
  parameter int ROB_SIZE  = `ROB_SIZE,
  parameter int NUM_D_REG = `NUM_D_REG,
  parameter int NUM_S_REG = `NUM_S_REG,
  localparam int PTR_W = $clog2(ROB_SIZE),
  localparam int CNT_W = PTR_W + 1,
  localparam int DW    = $clog2(NUM_D_REG),
  localparam int SW    = $clog2(NUM_S_REG)
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             alloc_valid,
  input  logic             alloc_write_d,
  input  logic [DW-1:0]    alloc_prev_rw_addr,
  input  logic             alloc_write_s,
  input  logic [SW-1:0]    alloc_prev_rs_addr,
  output logic             alloc_ready,
  output logic [PTR_W-1:0] alloc_rob_addr,
  input  logic             done_valid,
  input  logic [PTR_W-1:0] done_rob_addr,
  output logic             commit_valid,
  output logic [PTR_W-1:0] commit_rob_addr,
  output logic             free_d_valid,
  output logic [DW-1:0]    free_d_addr,
  output logic             free_s_valid,
  output logic [SW-1:0]    free_s_addr,
  output logic [CNT_W-1:0] count,
  output logic             empty
);

  rob_entry_t       entries [ROB_SIZE];
  rob_entry_t       head_entry;
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic             accept;
  logic             retire;

  // Full is judged on registered count alone, so a retiring full ROB still refuses.
  assign alloc_ready    = (count < CNT_W'(ROB_SIZE));
  assign accept         = alloc_valid && alloc_ready;
  assign head_entry     = entries[head];
  assign retire         = head_entry.occupied && head_entry.done;
  assign alloc_rob_addr = tail;
  assign empty          = (count == '0);

  rob_ptr #(.WIDTH(PTR_W)) u_head (
    .clk   (clk),
    .n_rst (n_rst),
    .inc   (retire),
    .ptr   (head)
  );

  rob_ptr #(.WIDTH(PTR_W)) u_tail (
    .clk   (clk),
    .n_rst (n_rst),
    .inc   (accept),
    .ptr   (tail)
  );

  // Allocation can never hit the retiring slot, so the priority order is only defensive.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      for (int i = 0; i < ROB_SIZE; i++) begin
        entries[i] <= '0;
      end
    end else begin
      for (int i = 0; i < ROB_SIZE; i++) begin
        if (accept && tail == PTR_W'(i)) begin
          entries[i].occupied     <= 1'b1;
          entries[i].done         <= 1'b0;
          entries[i].write_d      <= alloc_write_d;
          entries[i].prev_rw_addr <= alloc_prev_rw_addr;
          entries[i].write_s      <= alloc_write_s;
          entries[i].prev_rs_addr <= alloc_prev_rs_addr;
        end else if (retire && head == PTR_W'(i)) begin
          entries[i] <= '0;
        end else if (done_valid && done_rob_addr == PTR_W'(i) && entries[i].occupied) begin
          entries[i].done <= 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      count <= '0;
    end else begin
      unique case ({accept, retire})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Addresses are forced to zero whenever their strobe is low.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      commit_valid    <= 1'b0;
      commit_rob_addr <= '0;
      free_d_valid    <= 1'b0;
      free_d_addr     <= '0;
      free_s_valid    <= 1'b0;
      free_s_addr     <= '0;
    end else begin
      commit_valid    <= retire;
      commit_rob_addr <= retire ? head : '0;
      free_d_valid    <= retire && head_entry.write_d;
      free_d_addr     <= (retire && head_entry.write_d) ? head_entry.prev_rw_addr : '0;
      free_s_valid    <= retire && head_entry.write_s;
      free_s_addr     <= (retire && head_entry.write_s) ? head_entry.prev_rs_addr : '0;
    end
  end

endmodule
